// File: rtl/operand_b_stage.sv
// Operand-B selector for the execute path: picks rs2, a forwarded result or an
// extended immediate per opcode class. The result is held in a one-entry
// valid/ready pipeline register.
module operand_b_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [5:0]                  opcode,
  input  logic [REG_AW-1:0]           rs2_addr,
  input  logic [DATA_W-1:0]           reg_rs2,
  input  logic [IMM_W-1:0]            imme_value,
  input  logic [NUM_FWD-1:0]          fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0]   fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [5:0]                  out_opcode,
  output logic [DATA_W-1:0]           opb_out,
  output logic [1:0]                  opb_src,
  output logic                        illegal,
  output logic [15:0]                 fwd_hits
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_REG  = 2'b01;
  localparam logic [1:0] SRC_IMM  = 2'b10;
  localparam logic [1:0] SRC_FWD  = 2'b11;

  logic                accept_c;
  logic                fwd_found_c;
  logic [DATA_W-1:0]   fwd_sel_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic [1:0]          sel_src_c;
  logic                sel_illegal_c;

  logic                out_valid_d, out_valid_q;
  logic [5:0]          opcode_d, opcode_q;
  logic [DATA_W-1:0]   opb_d, opb_q;
  logic [1:0]          src_d, src_q;
  logic                illegal_d, illegal_q;
  logic [15:0]         hits_d, hits_q;

  // Single-entry handshake: free when empty or when being popped this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept_c = in_valid && in_ready;

  // Bypass match; scanning downward lets the lowest (youngest) index win.
  always_comb begin
    fwd_found_c = 1'b0;
    fwd_sel_c   = reg_rs2;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_addr[i*REG_AW +: REG_AW] == rs2_addr) &&
          (rs2_addr != '0)) begin
        fwd_found_c = 1'b1;
        fwd_sel_c   = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Per-opcode operand selection; unknown opcodes yield zero and flag illegal.
  always_comb begin
    sel_data_c    = '0;
    sel_src_c     = SRC_NONE;
    sel_illegal_c = 1'b0;
    case (opcode)
      6'd1, 6'd2, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14: begin
        sel_data_c = fwd_sel_c;
        sel_src_c  = fwd_found_c ? SRC_FWD : SRC_REG;
      end
      6'd3, 6'd4, 6'd16, 6'd19, 6'd20: begin
        sel_data_c = DATA_W'($signed(imme_value));
        sel_src_c  = SRC_IMM;
      end
      6'd17, 6'd18: begin
        sel_data_c = DATA_W'(imme_value[SH_W-1:0]);
        sel_src_c  = SRC_IMM;
      end
      6'd5, 6'd15: begin
        sel_data_c = '0;
        sel_src_c  = SRC_NONE;
      end
      default: begin
        sel_illegal_c = 1'b1;
      end
    endcase
  end

  // Next state of the holding register and hit counter.
  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    opb_d       = opb_q;
    src_d       = src_q;
    illegal_d   = illegal_q;
    hits_d      = hits_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      opcode_d    = opcode;
      opb_d       = sel_data_c;
      src_d       = sel_src_c;
      illegal_d   = sel_illegal_c;
      if ((sel_src_c == SRC_FWD) && (hits_q != 16'hFFFF)) begin
        hits_d = hits_q + 16'd1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      opb_q       <= '0;
      src_q       <= SRC_NONE;
      illegal_q   <= 1'b0;
      hits_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      opb_q       <= opb_d;
      src_q       <= src_d;
      illegal_q   <= illegal_d;
      hits_q      <= hits_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_opcode = opcode_q;
  assign opb_out    = opb_q;
  assign opb_src    = src_q;
  assign illegal    = illegal_q;
  assign fwd_hits   = hits_q;

endmodule

// File: tb/tb_operand_b_stage.sv
// Bench for operand_b_stage: a reference model of the holding register, checked
// every negative edge, plus directed scenarios with hand-computed expectations.
module tb_operand_b_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] reg_rs2 = '0;
  logic [15:0] imme_value = '0;
  logic [1:0]  fwd_valid = '0;
  logic [9:0]  fwd_addr = '0;
  logic [63:0] fwd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  out_opcode;
  logic [31:0] opb_out;
  logic [1:0]  opb_src;
  logic        illegal;
  logic [15:0] fwd_hits;

  int n_checks = 0;
  int n_pass   = 0;

  operand_b_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs2_addr(rs2_addr), .reg_rs2(reg_rs2),
    .imme_value(imme_value), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .opb_out(opb_out), .opb_src(opb_src),
    .illegal(illegal), .fwd_hits(fwd_hits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // What the operand must be for a given instruction, straight from the opcode table.
  typedef struct packed { logic [31:0] d; logic [1:0] s; logic ill; } exp_t;

  function automatic exp_t model_sel(input logic [5:0] op, input logic [4:0] rs2,
                                     input logic [31:0] rv, input logic [15:0] imm,
                                     input logic [1:0] fv, input logic [9:0] fa,
                                     input logic [63:0] fd);
    exp_t r;
    int sv;
    r = '{d: 32'd0, s: 2'd0, ill: 1'b0};
    if (op inside {1, 2, [6:14]}) begin
      r.d = rv;
      r.s = 2'd1;
      if (rs2 != 0) begin
        for (int i = 0; i < 2; i++) begin
          if (fv[i] && fa[i*5 +: 5] == rs2) begin
            r.d = fd[i*32 +: 32];
            r.s = 2'd3;
            break;
          end
        end
      end
    end else if (op inside {3, 4, 16, 19, 20}) begin
      sv  = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
      r.d = 32'(sv);
      r.s = 2'd2;
    end else if (op inside {17, 18}) begin
      r.d = 32'(imm % 32);
      r.s = 2'd2;
    end else if (op inside {5, 15}) begin
      r.s = 2'd0;
    end else begin
      r.ill = 1'b1;
    end
    return r;
  endfunction

  logic        m_valid = 1'b0;
  logic [5:0]  m_op = '0;
  exp_t        m_e = '0;
  int          m_hits = 0;

  // Reference register: updated on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_op    = '0;
      m_e     = '0;
      m_hits  = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid = 1'b1;
      m_op    = opcode;
      m_e     = model_sel(opcode, rs2_addr, reg_rs2, imme_value, fwd_valid, fwd_addr, fwd_data);
      if (m_e.s == 2'd3 && m_hits < 65535) m_hits = m_hits + 1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  // Cycle-by-cycle comparison of the DUT against the reference.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_fwd_hits", 32'(fwd_hits), 32'(m_hits));
      if (m_valid) begin
        chk("cyc_opcode", 32'(out_opcode), 32'(m_op));
        chk("cyc_opb", opb_out, m_e.d);
        chk("cyc_src", 32'(opb_src), 32'(m_e.s));
        chk("cyc_illegal", 32'(illegal), 32'(m_e.ill));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs2, input logic [31:0] rv,
                       input logic [15:0] imm, input logic [1:0] fv,
                       input logic [4:0] fa0, input logic [31:0] fd0,
                       input logic [4:0] fa1, input logic [31:0] fd1);
    in_valid   = 1'b1;
    opcode     = op;
    rs2_addr   = rs2;
    reg_rs2    = rv;
    imme_value = imm;
    fwd_valid  = fv;
    fwd_addr   = {fa1, fa0};
    fwd_data   = {fd1, fd0};
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_opb", opb_out, 32'd0);
    chk("rst_src", 32'(opb_src), 32'd0);
    chk("rst_opcode", 32'(out_opcode), 32'd0);
    chk("rst_hits", 32'(fwd_hits), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Immediates: sign extension and shift-amount truncation
    drive(6'd19, 5'd0, 32'h0, 16'hFFF0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("addi_opb", opb_out, 32'hFFFF_FFF0);
    chk("addi_src", 32'(opb_src), 32'd2);
    drive(6'd17, 5'd0, 32'h0, 16'h0123, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("sli_opb", opb_out, 32'h0000_0003);

    // Forwarding priority and register-0 exclusion
    drive(6'd1, 5'd5, 32'h1111, 16'h0, 2'b11, 5'd5, 32'hAAAA, 5'd5, 32'hBBBB);
    tick();
    chk("fwd0_opb", opb_out, 32'h0000_AAAA);
    chk("fwd0_src", 32'(opb_src), 32'd3);
    chk("fwd0_hits", 32'(fwd_hits), 32'd1);
    drive(6'd1, 5'd0, 32'h1111, 16'h0, 2'b11, 5'd0, 32'hAAAA, 5'd0, 32'hBBBB);
    tick();
    chk("r0_opb", opb_out, 32'h0000_1111);
    chk("r0_src", 32'(opb_src), 32'd1);
    drive(6'd12, 5'd7, 32'h1111, 16'h0, 2'b10, 5'd7, 32'hAAAA, 5'd7, 32'hBBBB);
    tick();
    chk("fwd1_opb", opb_out, 32'h0000_BBBB);
    chk("fwd1_hits", 32'(fwd_hits), 32'd2);

    // Backpressure: outputs frozen while inputs change
    drive(6'd2, 5'd3, 32'h1234, 16'h0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(6'd1, 5'd4, 32'h9999 + 32'(k), 16'h55, 2'b01, 5'd4, 32'hCCCC, 5'd0, 32'h0);
      tick();
      chk("stall_opb", opb_out, 32'h0000_1234);
      chk("stall_opcode", 32'(out_opcode), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    drive(6'd1, 5'd4, 32'h9999, 16'h0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("release_opb", opb_out, 32'h0000_9999);
    chk("release_valid", 32'(out_valid), 32'd1);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    tick();
    chk("prerst_hits", 32'(fwd_hits), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_hits", 32'(fwd_hits), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();

    // Back-to-back stream, one result per cycle
    for (int k = 0; k < 8; k++) begin
      drive(6'd19, 5'd0, 32'h0, 16'(k * 3 + 1), 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      chk("stream_opb", opb_out, 32'(k * 3 + 1));
      chk("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Illegal and no-operand opcodes
    drive(6'd0, 5'd1, 32'hDEAD, 16'hFFFF, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("op0_opb", opb_out, 32'd0);
    chk("op0_ill", 32'(illegal), 32'd1);
    opcode = 6'd21;
    tick();
    chk("op21_ill", 32'(illegal), 32'd1);
    opcode = 6'd63;
    tick();
    chk("op63_opb", opb_out, 32'd0);
    chk("op63_ill", 32'(illegal), 32'd1);
    opcode = 6'd15;
    tick();
    chk("not_opb", opb_out, 32'd0);
    chk("not_ill", 32'(illegal), 32'd0);
    chk("not_src", 32'(opb_src), 32'd0);

    // Hit counter saturation
    drive(6'd1, 5'd5, 32'h1, 16'h0, 2'b01, 5'd5, 32'h77, 5'd0, 32'h0);
    for (int k = 0; k < 65540; k++) tick();
    chk("sat_hits", 32'(fwd_hits), 32'h0000_FFFF);
    in_valid = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
